// File: rtl/kv_defines_pkg.sv
// kv_defines_pkg: shared keyvault read-port constants and types.
package kv_defines_pkg;
    localparam int KV_ENTRY_ADDR_W = 5;
    localparam int KV_ENTRY_SIZE_W = 4;
    localparam int KV_NUM_DWORDS   = 16;
    typedef enum logic [1:0] {IDLE, READ, DONE} kv_rd_arb_state_e;
endpackage

// File: rtl/kv_read_arbiter_if.sv
// kv_read_arbiter_if: requester handshake, keyvault read port and read-data return bus.
interface kv_read_arbiter_if import kv_defines_pkg::*; #(
    parameter int NUM_REQ  = 4,
    parameter int ENTRY_W  = KV_ENTRY_ADDR_W,
    parameter int OFFSET_W = KV_ENTRY_SIZE_W
);
    logic [NUM_REQ-1:0]         req_vld;
    logic [NUM_REQ*ENTRY_W-1:0] req_entry;
    logic [NUM_REQ-1:0]         gnt;
    logic [ENTRY_W-1:0]         kv_read_entry;
    logic [OFFSET_W-1:0]        kv_read_offset;
    logic [31:0]                kv_rd_data;
    logic                       kv_rd_last;
    logic                       kv_rd_error;
    logic [31:0]                rd_data;
    logic [NUM_REQ-1:0]         rd_vld;
    logic [OFFSET_W-1:0]        rd_offset;
    logic [NUM_REQ-1:0]         done;
    logic                       done_err;
    logic                       busy;
    modport slave (
        input  req_vld, req_entry, kv_rd_data, kv_rd_last, kv_rd_error,
        output gnt, kv_read_entry, kv_read_offset, rd_data, rd_vld, rd_offset, done, done_err, busy
    );
    modport master (
        output req_vld, req_entry, kv_rd_data, kv_rd_last, kv_rd_error,
        input  gnt, kv_read_entry, kv_read_offset, rd_data, rd_vld, rd_offset, done, done_err, busy
    );
endinterface

// File: rtl/kv_read_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, first request at or after ptr wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int PW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PW-1:0]      win
);
    logic [PW-1:0] idx;
    // Scan from farthest to nearest so the slot closest to ptr overwrites the rest.
    always_comb begin
        win = '0;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr) + i) % NUM_REQ);
            if (req[idx]) win = idx;
        end
        gnt = |req ? NUM_REQ'(1) << win : '0;
    end
endmodule

// File: rtl/kv_read_arbiter.sv
// kv_read_arbiter: round-robin sharing of one keyvault read port, one whole entry per grant.
module kv_read_arbiter import kv_defines_pkg::*; #(
    parameter int NUM_REQ    = 4,
    parameter int ENTRY_W    = KV_ENTRY_ADDR_W,
    parameter int OFFSET_W   = KV_ENTRY_SIZE_W,
    parameter int MAX_DWORDS = KV_NUM_DWORDS
) (
    input logic clk,
    input logic rst_b,
    input logic zeroize,
    kv_read_arbiter_if.slave bus
);
    localparam int PW = $clog2(NUM_REQ);
    localparam logic [OFFSET_W-1:0] CNT_MAX = OFFSET_W'(MAX_DWORDS - 1);

    kv_rd_arb_state_e    state_q, state_d;
    logic [OFFSET_W-1:0] cnt_q, rd_offset_q;
    logic [ENTRY_W-1:0]  entry_q;
    logic [PW-1:0]       owner_q, rr_ptr_q, arb_win;
    logic [NUM_REQ-1:0]  arb_gnt, owner_oh, rd_vld_q;
    logic [31:0]         rd_data_q;
    logic                err_q, stop;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req(bus.req_vld),
        .ptr(rr_ptr_q),
        .gnt(arb_gnt),
        .win(arb_win)
    );

    assign owner_oh = NUM_REQ'(1) << owner_q;
    assign stop     = bus.kv_rd_error || bus.kv_rd_last || cnt_q == CNT_MAX;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = |bus.req_vld ? READ : IDLE;
            READ:    state_d = stop ? DONE : READ;
            default: state_d = IDLE;
        endcase
        if (zeroize) state_d = IDLE;
        bus.gnt            = (state_q == IDLE && !zeroize) ? arb_gnt : '0;
        bus.done           = (state_q == DONE && !zeroize) ? owner_oh : '0;
        bus.done_err       = state_q == DONE && !zeroize && err_q;
        bus.kv_read_entry  = state_q == READ ? entry_q : '0;
        bus.kv_read_offset = state_q == READ ? cnt_q : '0;
        bus.busy           = state_q != IDLE;
    end

    // Errored dwords are scrubbed by the keyvault, so they only set err and never reach rd_data.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q       <= '0;
            entry_q     <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            err_q       <= 1'b0;
            rd_data_q   <= '0;
            rd_vld_q    <= '0;
            rd_offset_q <= '0;
        end else if (zeroize) begin
            cnt_q       <= '0;
            entry_q     <= '0;
            err_q       <= 1'b0;
            rd_data_q   <= '0;
            rd_vld_q    <= '0;
            rd_offset_q <= '0;
        end else begin
            rd_vld_q <= '0;
            if (state_q == IDLE && |bus.req_vld) begin
                owner_q <= arb_win;
                entry_q <= bus.req_entry[arb_win*ENTRY_W +: ENTRY_W];
                cnt_q   <= '0;
            end
            if (state_q == READ && bus.kv_rd_error) err_q <= 1'b1;
            if (state_q == READ && !bus.kv_rd_error) begin
                rd_data_q   <= bus.kv_rd_data;
                rd_offset_q <= cnt_q;
                rd_vld_q    <= owner_oh;
                cnt_q       <= stop ? cnt_q : cnt_q + 1'b1;
            end
            if (state_q == DONE) begin
                rr_ptr_q <= owner_q == PW'(NUM_REQ - 1) ? '0 : owner_q + 1'b1;
                err_q    <= 1'b0;
            end
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_vld    = rd_vld_q;
    assign bus.rd_offset = rd_offset_q;

    a_gnt_oh:  assert property (@(posedge clk) disable iff (!rst_b) $onehot0(bus.gnt));
    a_vld_oh:  assert property (@(posedge clk) disable iff (!rst_b) $onehot0(bus.rd_vld));
    a_done_oh: assert property (@(posedge clk) disable iff (!rst_b) $onehot0(bus.done));
    a_idle_off: assert property (@(posedge clk) disable iff (!rst_b) !bus.busy |-> bus.kv_read_offset == '0);
endmodule

// File: tb/tb_kv_read_arbiter.sv
// tb_kv_read_arbiter: directed scenarios against a combinational keyvault model.
module tb_kv_read_arbiter;
    import kv_defines_pkg::*;
    localparam int N = 4, EW = 5, OW = 4;

    logic clk = 1'b0, rst_b = 1'b0, zeroize = 1'b0;
    int checks = 0, errors = 0, cyc = 0, last_off = -1, err_off = -1;
    int g_cyc[$], g_idx[$], r_cyc[$], r_own[$], r_off[$], d_cyc[$], d_own[$], d_err[$];
    logic [31:0] r_dat[$];

    always #5 clk = ~clk;

    kv_read_arbiter_if #(.NUM_REQ(N), .ENTRY_W(EW), .OFFSET_W(OW)) bus ();
    kv_read_arbiter #(.NUM_REQ(N), .ENTRY_W(EW), .OFFSET_W(OW), .MAX_DWORDS(16)) dut (
        .clk(clk), .rst_b(rst_b), .zeroize(zeroize), .bus(bus)
    );

    function automatic logic [31:0] kv_word(input logic [EW-1:0] e, input logic [OW-1:0] o);
        return 32'hC0DE_0000 | {19'd0, e, 4'd0, o};
    endfunction

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    always_comb begin
        bus.kv_rd_data  = kv_word(bus.kv_read_entry, bus.kv_read_offset);
        bus.kv_rd_last  = int'(bus.kv_read_offset) == last_off;
        bus.kv_rd_error = int'(bus.kv_read_offset) == err_off;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (rst_b) begin
        if (|bus.gnt) begin g_cyc.push_back(cyc); g_idx.push_back(idx_of(bus.gnt)); end
        if (|bus.rd_vld) begin
            r_cyc.push_back(cyc); r_own.push_back(idx_of(bus.rd_vld));
            r_off.push_back(int'(bus.rd_offset)); r_dat.push_back(bus.rd_data);
        end
        if (|bus.done) begin
            d_cyc.push_back(cyc); d_own.push_back(idx_of(bus.done)); d_err.push_back(int'(bus.done_err));
        end
    end

    task automatic clear_logs();
        g_cyc.delete(); g_idx.delete(); r_cyc.delete(); r_own.delete(); r_off.delete();
        r_dat.delete(); d_cyc.delete(); d_own.delete(); d_err.delete();
    endtask

    task automatic start_single(input int r, input logic [EW-1:0] e, output int t);
        @(posedge clk); #1;
        bus.req_entry[r*EW +: EW] = e;
        bus.req_vld = N'(1) << r;
        @(negedge clk); #1;
        t = cyc;
        @(posedge clk); #1;
        bus.req_vld = '0;
    endtask

    task automatic wait_done(input int n, input int budget, input string name);
        for (int k = 0; k < budget && d_cyc.size() < n; k++) begin @(negedge clk); #1; end
        checks++;
        if (d_cyc.size() < n) begin
            errors++;
            $display("FAIL %s timeout: done count %0d required %0d", name, d_cyc.size(), n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.req_vld = '0; bus.req_entry = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.gnt, bus.rd_vld, bus.done, bus.done_err, bus.busy} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: gnt=%b rd_vld=%b done=%b err=%b busy=%b required all 0",
                     bus.gnt, bus.rd_vld, bus.done, bus.done_err, bus.busy);
        end
        checks++;
        if ({bus.rd_data, bus.rd_offset, bus.kv_read_entry, bus.kv_read_offset} !== '0) begin
            errors++;
            $display("FAIL reset_data: rd_data=%h rd_offset=%0d entry=%0d offset=%0d required 0",
                     bus.rd_data, bus.rd_offset, bus.kv_read_entry, bus.kv_read_offset);
        end
        rst_b = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%b required 0", bus.busy); end
    endtask

    task automatic test_round_robin();
        clear_logs(); last_off = 1; err_off = -1;
        bus.req_entry = {5'd4, 5'd3, 5'd2, 5'd1};
        @(posedge clk); #1;
        bus.req_vld = 4'b1111;
        for (int k = 0; k < 60 && g_cyc.size() < 5; k++) begin @(negedge clk); #1; end
        @(posedge clk); #1;
        bus.req_vld = '0;
        wait_done(5, 40, "rr_done");
        checks++;
        if (g_cyc.size() != 5 || d_cyc.size() != 5 || r_cyc.size() != 10) begin
            errors++;
            $display("FAIL rr_counts: gnt=%0d done=%0d rd=%0d required 5 5 10", g_cyc.size(), d_cyc.size(), r_cyc.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (g_idx[k] != k % 4 || d_own[k] != k % 4 || d_err[k] != 0 || d_cyc[k] != g_cyc[k] + 3) begin
                    errors++;
                    $display("FAIL rr_xfer%0d: gnt=%0d done_own=%0d err=%0d done_lat=%0d required %0d %0d 0 3",
                             k, g_idx[k], d_own[k], d_err[k], d_cyc[k] - g_cyc[k], k % 4, k % 4);
                end
                if (k < 4) begin
                    checks++;
                    if (g_cyc[k+1] != d_cyc[k] + 1) begin
                        errors++;
                        $display("FAIL rr_gap%0d: next gnt at %0d required %0d", k, g_cyc[k+1], d_cyc[k] + 1);
                    end
                end
                checks++;
                if (r_dat[2*k+1] !== kv_word(5'(k % 4 + 1), 4'd1) || r_own[2*k] != k % 4) begin
                    errors++;
                    $display("FAIL rr_data%0d: data=%h own=%0d required %h %0d", k, r_dat[2*k+1], r_own[2*k],
                             kv_word(5'(k % 4 + 1), 4'd1), k % 4);
                end
            end
        end
    endtask

    task automatic test_single_entry();
        int t;
        clear_logs(); last_off = 11; err_off = -1;
        start_single(0, 5'd3, t);
        wait_done(1, 40, "single_done");
        checks++;
        if (g_cyc.size() != 1 || g_idx[0] != 0 || g_cyc[0] != t || r_cyc.size() != 12) begin
            errors++;
            $display("FAIL single_counts: gnts=%0d rd=%0d required 1 12", g_cyc.size(), r_cyc.size());
        end else begin
            for (int k = 0; k < 12; k++) begin
                checks++;
                if (r_cyc[k] != t + 2 + k || r_own[k] != 0 || r_off[k] != k || r_dat[k] !== kv_word(5'd3, 4'(k))) begin
                    errors++;
                    $display("FAIL single_dw%0d: lat=%0d own=%0d off=%0d data=%h required %0d 0 %0d %h",
                             k, r_cyc[k] - t, r_own[k], r_off[k], r_dat[k], 2 + k, k, kv_word(5'd3, 4'(k)));
                end
            end
        end
        checks++;
        if (d_cyc.size() != 1 || d_cyc[0] != t + 13 || d_own[0] != 0 || d_err[0] != 0) begin
            errors++;
            $display("FAIL single_done: count=%0d lat=%0d own=%0d err=%0d required 1 13 0 0",
                     d_cyc.size(), d_cyc[0] - t, d_own[0], d_err[0]);
        end
    endtask

    task automatic test_error_first();
        int t;
        clear_logs(); last_off = -1; err_off = 0;
        start_single(2, 5'd7, t);
        wait_done(1, 20, "err0_done");
        checks++;
        if (r_cyc.size() != 0) begin errors++; $display("FAIL err0_rd: rd count %0d required 0", r_cyc.size()); end
        checks++;
        if (d_cyc.size() != 1 || d_cyc[0] != t + 2 || d_own[0] != 2 || d_err[0] != 1) begin
            errors++;
            $display("FAIL err0_done: lat=%0d own=%0d err=%0d required 2 2 1", d_cyc[0] - t, d_own[0], d_err[0]);
        end
    endtask

    task automatic test_cap();
        int t;
        clear_logs(); last_off = -1; err_off = -1;
        start_single(3, 5'd31, t);
        wait_done(1, 40, "cap_done");
        checks++;
        if (r_cyc.size() != 16) begin
            errors++; $display("FAIL cap_count: rd count %0d required 16", r_cyc.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                checks++;
                if (r_cyc[k] != t + 2 + k || r_own[k] != 3 || r_off[k] != k || r_dat[k] !== kv_word(5'd31, 4'(k))) begin
                    errors++;
                    $display("FAIL cap_dw%0d: lat=%0d own=%0d off=%0d data=%h required %0d 3 %0d",
                             k, r_cyc[k] - t, r_own[k], r_off[k], r_dat[k], 2 + k, k);
                end
            end
        end
        checks++;
        if (d_cyc.size() != 1 || d_cyc[0] != t + 17 || d_own[0] != 3 || d_err[0] != 0) begin
            errors++;
            $display("FAIL cap_done: lat=%0d own=%0d err=%0d required 17 3 0", d_cyc[0] - t, d_own[0], d_err[0]);
        end
    endtask

    task automatic test_error_mid();
        int t;
        clear_logs(); last_off = -1; err_off = 5;
        start_single(1, 5'd9, t);
        wait_done(1, 30, "err5_done");
        checks++;
        if (r_cyc.size() != 5 || r_off[0] != 0 || r_off[4] != 4 || r_dat[4] !== kv_word(5'd9, 4'd4)) begin
            errors++;
            $display("FAIL err5_rd: rd count %0d last_off=%0d required 5 4", r_cyc.size(), r_off[4]);
        end
        checks++;
        if (d_cyc.size() != 1 || d_cyc[0] != t + 7 || d_own[0] != 1 || d_err[0] != 1) begin
            errors++;
            $display("FAIL err5_done: lat=%0d own=%0d err=%0d required 7 1 1", d_cyc[0] - t, d_own[0], d_err[0]);
        end
    endtask

    task automatic test_zeroize();
        int t, k;
        clear_logs(); last_off = -1; err_off = -1;
        start_single(3, 5'd5, t);
        for (k = 0; k < 20 && bus.kv_read_offset != 4'd7; k++) begin @(negedge clk); #1; end
        checks++;
        if (cyc != t + 8) begin errors++; $display("FAIL zero_setup: offset 7 at lat %0d required 8", cyc - t); end
        zeroize = 1'b1;
        @(posedge clk); #1;
        zeroize = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.rd_vld, bus.rd_data, bus.rd_offset, bus.done, bus.done_err, bus.gnt,
             bus.kv_read_entry, bus.kv_read_offset} !== '0) begin
            errors++;
            $display("FAIL zero_outs: busy=%b rd_vld=%b rd_data=%h rd_off=%0d done=%b entry=%0d off=%0d required 0",
                     bus.busy, bus.rd_vld, bus.rd_data, bus.rd_offset, bus.done, bus.kv_read_entry, bus.kv_read_offset);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (r_cyc.size() != 7 || d_cyc.size() != 0) begin
            errors++;
            $display("FAIL zero_hist: rd count %0d done count %0d required 7 0", r_cyc.size(), d_cyc.size());
        end
        clear_logs(); last_off = 0;
        bus.req_entry = {5'd4, 5'd3, 5'd2, 5'd1};
        @(posedge clk); #1;
        bus.req_vld = 4'b1111;
        for (k = 0; k < 10 && g_cyc.size() < 1; k++) begin @(negedge clk); #1; end
        @(posedge clk); #1;
        bus.req_vld = '0;
        checks++;
        if (g_cyc.size() != 1 || g_idx[0] != 2) begin
            errors++;
            $display("FAIL zero_rrptr: grants=%0d winner=%0d required 1 2", g_cyc.size(), g_idx[0]);
        end
        wait_done(1, 20, "zero_after_done");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_single_entry();
        test_error_first();
        test_cap();
        test_error_mid();
        test_zeroize();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
